// File: rtl/branch_predictor_if.sv
// Fetch-lookup and Execute-resolution signals exchanged between the pipeline and the branch predictor.
// The pipeline holds the master modport; the predictor holds the slave modport.
interface branch_predictor_if;
  logic [31:0] pc_f_i;
  logic        pc_src_pred_f_o;
  logic [31:0] pred_pc_target_f_o;
  logic        valid_e_i;
  logic [1:0]  branch_op_e_i;
  logic        stall_e_i;
  logic [31:0] pc_e_i;
  logic [31:0] pc_plus4_e_i;
  logic [31:0] pc_target_e_i;
  logic        taken_e_i;
  logic        pc_src_pred_e_i;
  logic        target_match_e_i;
  logic        mispredict_e_o;
  logic [31:0] recovery_pc_e_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  modport master (
    output pc_f_i, valid_e_i, branch_op_e_i, stall_e_i, pc_e_i, pc_plus4_e_i,
           pc_target_e_i, taken_e_i, pc_src_pred_e_i, target_match_e_i,
    input  pc_src_pred_f_o, pred_pc_target_f_o, mispredict_e_o, recovery_pc_e_o,
           branch_count_o, mispredict_count_o
  );

  modport slave (
    input  pc_f_i, valid_e_i, branch_op_e_i, stall_e_i, pc_e_i, pc_plus4_e_i,
           pc_target_e_i, taken_e_i, pc_src_pred_e_i, target_match_e_i,
    output pc_src_pred_f_o, pred_pc_target_f_o, mispredict_e_o, recovery_pc_e_o,
           branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational Fetch lookup,
// Execute-stage training, mispredict/recovery generation and saturating perf counters.
module branch_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input logic               clk_i,
  input logic               reset_n_i,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LO  = INDEX_WIDTH + 2;
  localparam int TAG_HI  = INDEX_WIDTH + TAG_WIDTH + 1;

  logic [ENTRIES-1:0]   valid;
  logic [1:0]           ctr    [ENTRIES];
  logic [TAG_WIDTH-1:0] tag    [ENTRIES];
  logic [31:0]          target [ENTRIES];
  logic [31:0]          branch_count, mispredict_count;

  logic [INDEX_WIDTH-1:0] idx_f, idx_e;
  logic [TAG_WIDTH-1:0]   tag_f, tag_e;
  logic                   hit_f, hit_e, upd, mispredict;

  assign idx_f = bp.pc_f_i[INDEX_WIDTH+1:2];
  assign tag_f = bp.pc_f_i[TAG_HI:TAG_LO];
  assign idx_e = bp.pc_e_i[INDEX_WIDTH+1:2];
  assign tag_e = bp.pc_e_i[TAG_HI:TAG_LO];

  assign hit_f = valid[idx_f] && (tag[idx_f] == tag_f);
  assign hit_e = valid[idx_e] && (tag[idx_e] == tag_e);

  // Reset is folded into upd so a resolution arriving under reset neither trains nor flushes.
  assign upd = bp.valid_e_i && (bp.branch_op_e_i != 2'b00) && !bp.stall_e_i && reset_n_i;
  assign mispredict = upd && ((bp.taken_e_i != bp.pc_src_pred_e_i) ||
                              (bp.taken_e_i && bp.pc_src_pred_e_i && !bp.target_match_e_i));

  assign bp.pc_src_pred_f_o    = hit_f && ctr[idx_f][1];
  assign bp.pred_pc_target_f_o = hit_f ? target[idx_f] : 32'h0;
  assign bp.mispredict_e_o     = mispredict;
  assign bp.recovery_pc_e_o    = bp.taken_e_i ? bp.pc_target_e_i : bp.pc_plus4_e_i;
  assign bp.branch_count_o     = branch_count;
  assign bp.mispredict_count_o = mispredict_count;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd) begin
      if (hit_e) begin
        if (bp.taken_e_i) begin
          if (ctr[idx_e] != 2'b11) ctr[idx_e] <= ctr[idx_e] + 2'b01;
        end else if (ctr[idx_e] != 2'b00) begin
          ctr[idx_e] <= ctr[idx_e] - 2'b01;
        end
      end else if (bp.taken_e_i) begin
        valid[idx_e] <= 1'b1;
        ctr[idx_e]   <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (upd && bp.taken_e_i) begin
      tag[idx_e]    <= tag_e;
      target[idx_e] <= bp.pc_target_e_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd && branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (mispredict && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: an entry-level BTB model checked on every
// negedge, plus literal expectations from the hand-worked branch scenarios.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  branch_predictor_if bif ();
  branch_predictor #(.INDEX_WIDTH(6), .TAG_WIDTH(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bp(bif.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-slot record, confidence as an integer 0..3 (taken when >= 2).
  bit          m_v    [64];
  int unsigned m_tag  [64];
  int unsigned m_tgt  [64];
  int          m_conf [64];
  longint      m_bc, m_mc;

  function automatic int slot(input logic [31:0] pc);  return int'((pc / 4) % 64);  endfunction
  function automatic int unsigned ptag(input logic [31:0] pc); return (pc / 256) % 256; endfunction

  function automatic bit m_upd();
    return bif.valid_e_i && bif.branch_op_e_i != 0 && !bif.stall_e_i && rst_n;
  endfunction

  function automatic bit m_mispredict();
    return m_upd() && (bif.taken_e_i != bif.pc_src_pred_e_i ||
                       (bif.taken_e_i && bif.pc_src_pred_e_i && !bif.target_match_e_i));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin m_v[i] = 0; m_conf[i] = 1; end
      m_bc = 0; m_mc = 0;
    end else if (m_upd()) begin
      int s;
      bit mp;
      s  = slot(bif.pc_e_i);
      mp = m_mispredict();
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (m_v[s] && m_tag[s] == ptag(bif.pc_e_i)) begin
        if (bif.taken_e_i) begin
          m_conf[s] = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
          m_tgt[s]  = bif.pc_target_e_i;
        end else begin
          m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
        end
      end else if (bif.taken_e_i) begin
        m_v[s] = 1; m_tag[s] = ptag(bif.pc_e_i); m_tgt[s] = bif.pc_target_e_i; m_conf[s] = 2;
      end
    end
  end

  bit model_live = 0;
  always @(negedge clk) begin
    if (model_live) begin
      int s;
      bit hit, mp;
      s   = slot(bif.pc_f_i);
      hit = m_v[s] && m_tag[s] == ptag(bif.pc_f_i);
      mp  = m_mispredict();
      check("mdl_pred", {31'b0, bif.pc_src_pred_f_o}, {31'b0, hit && m_conf[s] >= 2});
      check("mdl_tgt", bif.pred_pc_target_f_o, hit ? m_tgt[s] : 32'h0);
      check("mdl_misp", {31'b0, bif.mispredict_e_o}, {31'b0, mp});
      if (mp) check("mdl_recov", bif.recovery_pc_e_o,
                    bif.taken_e_i ? bif.pc_target_e_i : bif.pc_e_i + 32'd4);
      check("mdl_bcnt", bif.branch_count_o, m_bc[31:0]);
      check("mdl_mcnt", bif.mispredict_count_o, m_mc[31:0]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit pred, input bit tm);
    bif.valid_e_i = 1; bif.branch_op_e_i = 2'b01; bif.pc_e_i = pc; bif.pc_plus4_e_i = pc + 4;
    bif.taken_e_i = tk; bif.pc_target_e_i = tgt; bif.pc_src_pred_e_i = pred;
    bif.target_match_e_i = tm;
  endtask

  task automatic idle();
    bif.valid_e_i = 0; bif.branch_op_e_i = 2'b00; bif.stall_e_i = 0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit pred,
                      input logic [31:0] tgt);
    bif.pc_f_i = pc; #1;
    check({name, "_pred"}, {31'b0, bif.pc_src_pred_f_o}, {31'b0, pred});
    check({name, "_tgt"}, bif.pred_pc_target_f_o, tgt);
  endtask

  task automatic misp(input string name, input bit mp, input logic [31:0] rec);
    #1;
    check({name, "_misp"}, {31'b0, bif.mispredict_e_o}, {31'b0, mp});
    if (mp) check({name, "_recov"}, bif.recovery_pc_e_o, rec);
  endtask

  task automatic counts(input string name, input logic [31:0] b, input logic [31:0] m);
    check({name, "_bcnt"}, bif.branch_count_o, b);
    check({name, "_mcnt"}, bif.mispredict_count_o, m);
  endtask

  initial begin
    bif.pc_f_i = 32'h100; bif.pc_e_i = 0; bif.pc_plus4_e_i = 4; bif.pc_target_e_i = 0;
    bif.taken_e_i = 0; bif.pc_src_pred_e_i = 0; bif.target_match_e_i = 0;
    idle();
    step(); step();
    rst_n = 1; model_live = 1;
    step();
    look("rst", 32'h100, 0, 32'h0);
    counts("rst", 0, 0);

    // Cold taken branch; same-cycle lookup sees pre-update contents.
    resolve(32'h100, 1, 32'h80, 0, 0);
    misp("cold", 1, 32'h80);
    look("cold_same", 32'h100, 0, 32'h0);
    step(); idle();
    look("cold_next", 32'h100, 1, 32'h80);
    counts("cold", 1, 1);

    // Walk down: 10 -> 01 -> 00.
    step(); resolve(32'h100, 0, 32'h80, 1, 0);
    misp("dn1", 1, 32'h104);
    step(); idle();
    look("dn1", 32'h100, 0, 32'h80);
    step(); resolve(32'h100, 0, 32'h80, 0, 0);
    misp("dn2", 0, 32'h0);
    step(); idle();
    counts("dn", 3, 2);

    // Not-taken miss at an empty slot allocates nothing.
    step(); resolve(32'h204, 0, 32'h300, 0, 0);
    misp("ntmiss", 0, 32'h0);
    step(); idle();
    look("ntmiss", 32'h204, 0, 32'h0);

    // Walk back up to 10, then retarget: 0x80 -> 0x90, counter 11.
    step(); resolve(32'h100, 1, 32'h80, 0, 0);
    step(); resolve(32'h100, 1, 32'h80, 0, 0);
    step(); idle();
    look("up", 32'h100, 1, 32'h80);
    step(); resolve(32'h100, 1, 32'h90, 1, 0);
    misp("retgt", 1, 32'h90);
    step(); idle();
    look("retgt", 32'h100, 1, 32'h90);
    counts("retgt", 7, 5);

    // Stalled resolution changes nothing.
    step(); resolve(32'h100, 0, 32'h90, 1, 0); bif.stall_e_i = 1;
    misp("stall", 0, 32'h0);
    step(); idle();
    look("stall", 32'h100, 1, 32'h90);
    counts("stall", 7, 5);

    // Aliasing: 0x4100 shares slot 0 with 0x100 and replaces it.
    step(); resolve(32'h4100, 1, 32'h200, 0, 0);
    misp("alias", 1, 32'h200);
    step(); idle();
    look("alias_old", 32'h100, 0, 32'h0);
    look("alias_new", 32'h4100, 1, 32'h200);

    // Reset wins over a same-cycle update.
    step(); resolve(32'h100, 1, 32'h80, 0, 0); rst_n = 0;
    misp("rstupd", 0, 32'h0);
    step(); idle(); rst_n = 1;
    look("rstupd", 32'h4100, 0, 32'h0);
    counts("rstupd", 0, 0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline. It provides taken/not-taken predictions and predicted targets to Fetch; those values travel down the pipeline as `pc_src_pred` and `pred_pc_target`. When a control-transfer instruction reaches Execute, the block takes its resolution, updates its tables and signals any misprediction with a recovery PC. Storage is a direct-mapped branch target buffer (BTB), where each entry holds a valid bit, a tag, a target and a 2-bit saturating counter. The block also keeps branch and mispredict performance counters.

## Interface
- INDEX_WIDTH, default 6: log2 of the BTB entry count (64 entries).
- TAG_WIDTH, default 8: number of tag bits stored per entry.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- pc_f_i  in  32  Fetch PC to look up.
- pc_src_pred_f_o  out  1  prediction for pc_f_i, 1 = taken.
- pred_pc_target_f_o  out  32  predicted target for pc_f_i.
- valid_e_i  in  1  the Execute instruction is valid.
- branch_op_e_i  in  2  2'b00 = not a control transfer; any nonzero value = branch or jump.
- stall_e_i  in  1  Execute stalled; the update is suppressed.
- pc_e_i  in  32  PC of the Execute instruction.
- pc_plus4_e_i  in  32  pc_e_i + 4.
- pc_target_e_i  in  32  resolved target.
- taken_e_i  in  1  resolved outcome, 1 = taken.
- pc_src_pred_e_i  in  1  prediction made for this instruction in Fetch.
- target_match_e_i  in  1  resolved target equals the predicted target.
- mispredict_e_o  out  1  flush request for Fetch and Decode, plus redirect.
- recovery_pc_e_o  out  32  PC to redirect Fetch to.
- branch_count_o  out  32  count of resolved control transfers.
- mispredict_count_o  out  32  count of mispredictions.

## Operation
- Address split:
  - idx = pc[INDEX_WIDTH+1:2].
  - tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
- Lookup:
  - hit = valid[idx_f] && tag[idx_f] == tag_f.
  - pc_src_pred_f_o = hit && ctr[idx_f][1].
  - pred_pc_target_f_o = target[idx_f] when hit, else 32'h0.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken.
  - 10 = weak taken, 11 = strong taken.
- Update enable: upd = valid_e_i && branch_op_e_i != 2'b00 && !stall_e_i && reset_n_i.
- Update when the entry at idx_e is a hit:
  - If taken: counter saturating-increments and target is written with pc_target_e_i.
  - If not taken: counter saturating-decrements; target is unchanged.
- Update when the entry at idx_e is a miss:
  - If taken: allocate or replace the entry, setting valid = 1, tag = tag_e, target = pc_target_e_i, counter = 10.
  - If not taken: the entry is left untouched.
- Mispredict: mispredict_e_o = upd && (taken_e_i != pc_src_pred_e_i || (taken_e_i && pc_src_pred_e_i && !target_match_e_i)).
- Recovery: recovery_pc_e_o = taken_e_i ? pc_target_e_i : pc_plus4_e_i. Only meaningful while mispredict_e_o = 1.
- Performance counters:
  - branch_count_o increments on upd.
  - mispredict_count_o increments on mispredict_e_o.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Reset, applied in one cycle:
  - All valid bits = 0 and all counters = 01.
  - Tags and targets don't-care.
  - Both performance counters = 0.
- Outputs after reset:
  - pc_src_pred_f_o = 0 and pred_pc_target_f_o = 0 for any PC.
  - mispredict_e_o = 0.

## Timing
- Lookup is purely combinational from pc_f_i. It adds zero cycles of latency and lands in the same cycle as Fetch.
- mispredict_e_o and recovery_pc_e_o are combinational from the Execute inputs, valid in the same cycle.
- Table and counter writes take effect at the rising edge that ends the upd cycle. They are visible to lookups from the next cycle onward.
- A lookup and an update to the same idx in the same cycle: the lookup returns pre-update contents, with no bypass.
- Reset asserted in a cycle with upd conditions true: reset wins, the update is dropped and mispredict_e_o = 0.
- stall_e_i = 1 while the Execute instruction is held: no update and no mispredict in that cycle. Each instruction is counted once, on its unstalled cycle.

## Test plan
- Reset behaviour: reset, then pc_f_i=0x100 -> pc_src_pred_f_o=0, pred_pc_target_f_o=0, both counters 0.
- Cold taken branch: resolve pc_e=0x100, taken, target 0x80, pred 0 -> mispredict=1, recovery=0x80. Next cycle, pc_f_i=0x100 -> pred=1, target=0x80; branch_count=1, mispredict_count=1.
- Counter walk-down: from the previous state, resolve 0x100 not-taken with pred 1 -> mispredict=1, recovery=0x104, counter 10->01, next lookup pred=0. Resolve not-taken again with pred 0 -> mispredict=0, counter 00.
- Aliasing: with 0x100 trained strong-taken, resolve 0x4100 taken, target 0x200 (same idx 0, tag 0x41 vs 0x01) -> entry replaced. Then lookup 0x100 -> pred=0, target=0; lookup 0x4100 -> pred=1, target=0x200.
- Target mismatch: entry for 0x100 holds target 0x80. Resolve taken to 0x90 with pred=1, target_match=0 -> mispredict=1, recovery=0x90; next lookup gives target 0x90.
- Stall and reset priority:
  - A resolution with stall_e_i=1 -> no table or counter change, mispredict=0.
  - The same resolution with reset_n_i=0 -> update dropped, all state at reset values.
  - Same-cycle lookup of the index being updated -> old values returned.
